// File: rtl/program_counter_ras.sv
// Program counter with sequential advance, jump/call/ret redirects and a
// circular return-address stack held in registers.
module program_counter_ras #(
    parameter int ADDR_W = 32,
    parameter int STEP = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(-STEP),
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic [ADDR_W-1:0]            target,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_next,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_underflow,
    output logic                         ras_overflow,
    output logic                         misaligned
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] aligned_target;
    logic              target_low_set;
    logic              do_ret;
    logic              do_call;
    logic              do_jump;

    // sp is the next write slot; when full it also points at the oldest
    // entry, so a push there naturally overwrites it.
    assign top_idx        = sp - 1'b1;
    assign seq_pc         = pc + STEP_V;
    assign aligned_target = target & ALIGN_MASK;
    assign target_low_set = |(target & ~ALIGN_MASK);

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == DEPTH_V);

    assign do_ret  = !stall && ret;
    assign do_call = !stall && call && !ret;
    assign do_jump = !stall && jump && !ret && !call;

    always_comb begin
        pc_next = seq_pc;
        if (stall) begin
            pc_next = pc;
        end else if (do_ret) begin
            pc_next = ras_empty ? aligned_target : stack_mem[top_idx];
        end else if (do_call || do_jump) begin
            pc_next = aligned_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_VEC;
            sp            <= '0;
            ras_count     <= '0;
            ras_underflow <= 1'b0;
            ras_overflow  <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_underflow <= do_ret && ras_empty;
            misaligned    <= (do_call || do_jump) && target_low_set;
            if (do_call && ras_full) begin
                ras_overflow <= 1'b1;
            end
            if (do_ret && !ras_empty) begin
                sp        <= sp - 1'b1;
                ras_count <= ras_count - 1'b1;
            end else if (do_call) begin
                sp <= sp + 1'b1;
                if (!ras_full) begin
                    ras_count <= ras_count + 1'b1;
                end
            end
        end
    end

    // Stale contents are harmless: only entries below ras_count are ever read.
    always_ff @(posedge clk) begin
        if (do_call) begin
            stack_mem[sp] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras at default parameters: one task per
// scenario with hand-computed expected pc / stack values.
module tb_program_counter_ras;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
    logic        ras_overflow;
    logic        misaligned;

    int n_cmp;
    int n_fail;

    program_counter_ras dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .jump(jump),
        .call(call),
        .ret(ret),
        .target(target),
        .pc(pc),
        .pc_next(pc_next),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_underflow(ras_underflow),
        .ras_overflow(ras_overflow),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of controls, take the edge, sample 1ns later, go idle.
    task automatic step(input logic j, input logic c, input logic r,
                        input logic s, input logic [31:0] t);
        jump = j; call = c; ret = r; stall = s; target = t;
        @(posedge clk);
        #1;
        jump = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0; target = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
        n_cmp++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        n_cmp++; if ({ras_empty, ras_full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full got=%b exp=10", {ras_empty, ras_full}); end
        n_cmp++; if ({ras_underflow, ras_overflow, misaligned} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {ras_underflow, ras_overflow, misaligned}); end
        n_cmp++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next got=%h exp=0", pc_next); end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
        end
    endtask

    task automatic test_call_ret();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        n_cmp++; if (pc !== 32'h10) begin n_fail++; $display("FAIL cr_jump got=%h exp=10", pc); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        n_cmp++; if (pc !== 32'h200 || ras_count !== 3'd1) begin n_fail++; $display("FAIL cr_call pc=%h cnt=%0d exp=200/1", pc, ras_count); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h204) begin n_fail++; $display("FAIL cr_seq1 got=%h exp=204", pc); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h208) begin n_fail++; $display("FAIL cr_seq2 got=%h exp=208", pc); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h14 || ras_count !== 3'd0) begin n_fail++; $display("FAIL cr_ret pc=%h cnt=%0d exp=14/0", pc, ras_count); end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] ret_addr [4];
        ret_addr[0] = 32'h404; ret_addr[1] = 32'h304; ret_addr[2] = 32'h204; ret_addr[3] = 32'h104;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'(i) << 8);
            n_cmp++; if (pc !== (32'(i) << 8)) begin n_fail++; $display("FAIL ovf_call[%0d] pc=%h exp=%h", i, pc, 32'(i) << 8); end
        end
        n_cmp++; if (ras_count !== 3'd4 || ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_count cnt=%0d full=%b exp=4/1", ras_count, ras_full); end
        n_cmp++; if (ras_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ras_overflow); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            n_cmp++; if (pc !== ret_addr[i] || ras_count !== 3'(3 - i)) begin n_fail++; $display("FAIL ovf_ret[%0d] pc=%h cnt=%0d exp=%h/%0d", i, pc, ras_count, ret_addr[i], 3 - i); end
        end
        n_cmp++; if (ras_overflow !== 1'b1 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky ovf=%b empty=%b exp=1/1", ras_overflow, ras_empty); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
        n_cmp++; if (pc !== 32'h80 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin n_fail++; $display("FAIL udf_ret pc=%h udf=%b cnt=%0d exp=80/1/0", pc, ras_underflow, ras_count); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h84 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL udf_pulse pc=%h udf=%b exp=84/0", pc, ras_underflow); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
            n_cmp++; if (pc !== 32'h20 || misaligned !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d] pc=%h mis=%b exp=20/0", i, pc, misaligned); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h24) begin n_fail++; $display("FAIL stall_release got=%h exp=24", pc); end
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        n_cmp++; if (pc !== 32'h24 || ras_count !== 3'd0) begin n_fail++; $display("FAIL stall_call pc=%h cnt=%0d exp=24/0", pc, ras_count); end
    endtask

    task automatic test_misaligned();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h103);
        n_cmp++; if (pc !== 32'h100 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_jump pc=%h mis=%b exp=100/1", pc, misaligned); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h104 || misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse pc=%h mis=%b exp=104/0", pc, misaligned); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h602);
        n_cmp++; if (pc !== 32'h600 || misaligned !== 1'b1 || ras_count !== 3'd1) begin n_fail++; $display("FAIL mis_call pc=%h mis=%b cnt=%0d exp=600/1/1", pc, misaligned, ras_count); end
    endtask

    task automatic test_ret_call_together();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h700);
        n_cmp++; if (pc !== 32'h108 || ras_count !== 3'd0) begin n_fail++; $display("FAIL retcall pc=%h cnt=%0d exp=108/0", pc, ras_count); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got=%h exp=FFFFFFFC", pc); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h0 || misaligned !== 1'b0 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL wrap pc=%h mis=%b udf=%b exp=0/0/0", pc, misaligned, ras_underflow); end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
        n_cmp++; if (ras_count !== 3'd2) begin n_fail++; $display("FAIL ar_setup cnt=%0d exp=2", ras_count); end
        call = 1'b1; ret = 1'b1; target = 32'h500;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'hFFFF_FFFC || ras_count !== 3'd0) begin n_fail++; $display("FAIL ar_immediate pc=%h cnt=%0d exp=FFFFFFFC/0", pc, ras_count); end
        n_cmp++; if (ras_overflow !== 1'b0) begin n_fail++; $display("FAIL ar_ovf_clear got=%b exp=0", ras_overflow); end
        @(posedge clk);
        #1;
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ar_held got=%h exp=FFFFFFFC", pc); end
        call = 1'b0; ret = 1'b0; target = 32'h0;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL ar_first_edge got=%h exp=0", pc); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h44);
        n_cmp++; if (pc !== 32'h44 || ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ar_discarded pc=%h udf=%b exp=44/1", pc, ras_underflow); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_sequential();
        test_call_ret();
        test_overflow_underflow();
        test_stall();
        test_misaligned();
        test_ret_call_together();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout pc=%h exp=finished", pc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_counter_ras.md
PROGRAM_COUNTER_RAS -- requirements
Module: program_counter_ras

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter STEP, default 4, meaning sequential increment in bytes (power of two, ≥1).
REQ-003 SHALL have parameter RESET_VEC, default -STEP truncated to ADDR_W bits (0xFFFFFFFC), so the first sequential advance fetches 0.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, ≥2).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 stall  input  1  hold the PC and the stack this cycle.
REQ-008 jump  input  1  redirect the PC to target.
REQ-009 call  input  1  redirect the PC to target and push pc+STEP.
REQ-010 ret  input  1  pop the stack and redirect the PC to the popped address.
REQ-011 target  input  ADDR_W  redirect address for jump/call, and the fallback address for ret on an empty stack.
REQ-012 pc  output  ADDR_W  registered current instruction address.
REQ-013 pc_next  output  ADDR_W  combinational value pc takes at the next edge.
REQ-014 ras_count  output  clog2(RAS_DEPTH)+1  registered number of valid stack entries.
REQ-015 ras_empty / ras_full  output  1 each  combinational decodes of ras_count == 0 and ras_count == RAS_DEPTH.
REQ-016 ras_underflow  output  1  registered single-cycle pulse.
REQ-017 ras_overflow  output  1  registered sticky flag.
REQ-018 misaligned  output  1  registered single-cycle pulse.

Function
REQ-019 Priority when stall=0 SHALL be ret > call > jump > sequential.
- With stall=1, pc, the stack and ras_count SHALL hold.
- With stall=1, all of jump/call/ret SHALL be ignored (not queued).
- With stall=1, ras_underflow and misaligned SHALL be 0 on the next cycle.
REQ-020 Sequential: pc_next = pc + STEP, modulo 2^ADDR_W.
- 0xFFFFFFFC SHALL wrap to 0x00000000 with no flag.
REQ-021 Jump: pc_next = target with its low clog2(STEP) bits forced to 0.
- misaligned SHALL pulse next cycle if any of those target bits were 1.
REQ-022 Call: same pc_next as jump.
- Additionally pushes (pc + STEP) mod 2^ADDR_W onto the stack; ras_count increments.
REQ-023 Call with ras_full: the push SHALL overwrite the oldest entry (circular buffer).
- ras_count SHALL stay at RAS_DEPTH.
- ras_overflow SHALL set and remain 1 until reset.
REQ-024 Ret with ras_count > 0: pc_next = top-of-stack entry; ras_count decrements.
REQ-025 Ret with ras_empty: pc_next = aligned target.
- ras_underflow SHALL pulse for one cycle.
- ras_count SHALL stay 0.
REQ-026 Ret and call asserted together: ret wins; pop only, no push.
REQ-027 Stack storage SHALL be registers.
- Entries beyond ras_count are don't-care and SHALL never drive pc.
REQ-028 pc_next SHALL be a pure function of the current state and inputs, with no combinational path from pc_next back into any input.
REQ-029 Redirect latency: a control asserted in cycle N with stall=0 SHALL appear on pc after the edge ending cycle N (1 cycle).

Reset
REQ-030 While rst=0, regardless of clk, the following SHALL hold:
- pc = RESET_VEC
- ras_count = 0
- ras_overflow = 0, ras_underflow = 0, misaligned = 0
- stack pointer = 0
REQ-031 Reset asserted mid-operation (pending call/ret, non-empty stack) SHALL discard all stack contents and all pending controls.
REQ-032 On the first rising edge after rst deasserts, with no control asserted and stall=0, pc SHALL become RESET_VEC + STEP (0x00000000 at defaults).

Verification
REQ-033 Reset release, idle inputs, three edges -> pc = 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
REQ-034 At pc=0x10, call target=0x200; then 2 sequential edges; then ret -> pc = 0x200, 0x204, 0x208, 0x14; ras_count goes 1 -> 0.
REQ-035 Five calls (RAS_DEPTH=4) from pc=0x0, 0x100, 0x200, 0x300, 0x400, then four rets -> ras_overflow=1, ras_count=4, and return addresses 0x404, 0x304, 0x204, 0x104 (0x4 lost).
REQ-036 Empty stack, ret with target=0x80 -> pc=0x80, one-cycle ras_underflow=1, ras_count=0.
REQ-037 Two cycles with stall=1 and jump=1, target=0x40, starting at pc=0x20 -> pc holds 0x20 through both cycles; release stall with jump deasserted -> pc=0x24.
REQ-038 jump target=0x103 -> pc=0x100, misaligned pulse; separately, rst=0 asynchronously mid-cycle with ras_count=2 -> pc=0xFFFFFFFC and ras_count=0 immediately, without waiting for a clock edge.
